mod_counter: RTL and testbench

//   Parametrised modulo-N up/down counter; successor to the fixed 3-bit

---
 rtl/mod_counter.sv | 108 ++++++++++
 tb/tb_mod_counter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mod_counter.sv
// ============================================================================
//  Module      : mod_counter
//  Description : Parametrised modulo-N up/down counter with count enable,
//                synchronous clamped load, combinational terminal count (tc)
//                and a registered one-cycle wrap pulse. Chain tc of one stage
//                into en of the next to cascade stages.
//  Revision    : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH   counter width in bits (>= 1)
//    MODULO  count range 0..MODULO-1, 2 <= MODULO <= 2**WIDTH
//  Ports
//    clk   in   1      rising-edge clock
//    rst   in   1      asynchronous, active-high reset
//    en    in   1      count enable
//    up    in   1      1 = count up, 0 = count down
//    load  in   1      synchronous load, priority over en
//    d     in   WIDTH  load value (clamped to MODULO-1)
//    q     out  WIDTH  current count (registered)
//    tc    out  1      terminal count (combinational)
//    wrap  out  1      registered pulse after a wrap/saturate edge
//  Build option
//    COUNTER_SAT_EN  defined: saturate at the boundary instead of wrapping.
// ============================================================================
`default_nettype none

module mod_counter #(
  parameter int WIDTH  = 3,
  parameter int MODULO = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;

  logic             w_bnd;
  logic             w_tc;
  logic [WIDTH-1:0] w_q_step;
  logic [WIDTH-1:0] w_q_load;
  logic [WIDTH-1:0] w_q_nxt;

  // Boundary depends on the live direction, so tc follows a change of up
  // in the same cycle.
  assign w_bnd = up ? (r_q == C_MAX) : (r_q == '0);
  assign w_tc  = en & ~load & w_bnd;

  // Out-of-range load values are clamped so q never leaves 0..MODULO-1.
  assign w_q_load = (d > C_MAX) ? C_MAX : d;

  always_comb begin
    w_q_step = r_q;
`ifdef COUNTER_SAT_EN
    // Hold at the boundary; stepping away (direction change) still works.
    if (w_bnd) begin
      w_q_step = r_q;
    end else if (up) begin
      w_q_step = r_q + C_ONE;
    end else begin
      w_q_step = r_q - C_ONE;
    end
`else
    if (up) begin
      w_q_step = w_bnd ? '0 : (r_q + C_ONE);
    end else begin
      w_q_step = w_bnd ? C_MAX : (r_q - C_ONE);
    end
`endif
  end

  always_comb begin
    w_q_nxt = r_q;
    if (load) begin
      w_q_nxt = w_q_load;
    end else if (en) begin
      w_q_nxt = w_q_step;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      // tc already excludes load and en=0, so this alone gives the pulse.
      r_wrap <= w_tc;
    end
  end

  assign q    = r_q;
  assign tc   = w_tc;
  assign wrap = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_mod_counter.sv
// ============================================================================
//  Module      : tb_mod_counter
//  Description : Scoreboard bench for mod_counter. Two instances share the
//                stimulus: u_dut8 (WIDTH=3, MODULO=8) and u_dut6 (WIDTH=3,
//                MODULO=6). Each step drives inputs on the falling edge and
//                queues the hand-computed q/tc/wrap expected for that cycle;
//                a monitor samples 3 ns later and compares.
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

module tb_mod_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [2:0] d;
  logic [2:0] q8, q6;
  logic       tc8, tc6, wrap8, wrap6;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string      name;
    bit         sel6;
    logic [2:0] q;
    logic       tc;
    logic       wrap;
  } exp_t;

  exp_t sb[$];

  mod_counter #(.WIDTH(3), .MODULO(8)) u_dut8 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
    .q(q8), .tc(tc8), .wrap(wrap8)
  );

  mod_counter #(.WIDTH(3), .MODULO(6)) u_dut6 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
    .q(q6), .tc(tc6), .wrap(wrap6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, exp);
    end
  endtask

  // Monitor: samples 3 ns after each falling edge, once inputs have settled
  // and well before the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.sel6) begin
          chk(e.name, "q",    int'(q6),    int'(e.q));
          chk(e.name, "tc",   int'(tc6),   int'(e.tc));
          chk(e.name, "wrap", int'(wrap6), int'(e.wrap));
        end else begin
          chk(e.name, "q",    int'(q8),    int'(e.q));
          chk(e.name, "tc",   int'(tc8),   int'(e.tc));
          chk(e.name, "wrap", int'(wrap8), int'(e.wrap));
        end
      end
    end
  end

  // Drive one cycle of stimulus and queue what the selected instance must
  // show during that cycle (q before the coming rising edge).
  task automatic step(input string nm, input bit s6,
                      input logic r, input logic e, input logic u,
                      input logic l, input logic [2:0] dd,
                      input logic [2:0] eq, input logic et, input logic ew);
    exp_t x;
    @(negedge clk);
    rst  = r;
    en   = e;
    up   = u;
    load = l;
    d    = dd;
    x.name = nm;
    x.sel6 = s6;
    x.q    = eq;
    x.tc   = et;
    x.wrap = ew;
    sb.push_back(x);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    up   = 1'b1;
    load = 1'b0;
    d    = 3'd0;

    // --- 1: reset and full up-count on MODULO=8 ---
    step("rst8",  0, 1, 0, 1, 0, 0, 3'd0, 0, 0);
    step("up8_0", 0, 0, 1, 1, 0, 0, 3'd0, 0, 0);
    for (int i = 1; i <= 7; i++)
      step("up8", 0, 0, 1, 1, 0, 0, 3'(i), (i == 7), 0);
    step("wrap8", 0, 0, 1, 1, 0, 0, 3'd0, 0, 1);
    step("post8", 0, 0, 1, 1, 0, 0, 3'd1, 0, 0);

    // --- 4: hold, then direction change at q=7 ---
    for (int i = 0; i < 3; i++)
      step("hold8", 0, 0, 0, 1, 0, 0, 3'd2, 0, 0);
    for (int i = 2; i <= 6; i++)
      step("climb8", 0, 0, 1, 1, 0, 0, 3'(i), 0, 0);
    step("dir8_7", 0, 0, 1, 0, 0, 0, 3'd7, 0, 0);
    step("dir8_6", 0, 0, 1, 0, 0, 0, 3'd6, 0, 0);
    step("at5",    0, 0, 0, 0, 0, 0, 3'd5, 0, 0);

    // --- 5: asynchronous reset between edges ---
    step("arst8",  0, 1, 1, 1, 0, 0, 3'd0, 0, 0);
    step("res8_0", 0, 0, 1, 1, 0, 0, 3'd0, 0, 0);
    step("res8_1", 0, 0, 1, 1, 0, 0, 3'd1, 0, 0);

    // --- 2: MODULO=6 up then down ---
    step("rst6", 1, 1, 0, 1, 0, 0, 3'd0, 0, 0);
    for (int i = 0; i <= 5; i++)
      step("up6", 1, 0, 1, 1, 0, 0, 3'(i), (i == 5), 0);
    step("dn6_0", 1, 0, 1, 0, 0, 0, 3'd0, 1, 1);
    step("dn6_5", 1, 0, 1, 0, 0, 0, 3'd5, 0, 1);
    step("dn6_4", 1, 0, 1, 0, 0, 0, 3'd4, 0, 0);

    // --- 3: load with clamp and tc suppression ---
    step("ld6_7",  1, 0, 1, 0, 1, 3'd7, 3'd3, 0, 0);
    step("ld6_3",  1, 0, 1, 1, 1, 3'd3, 3'd5, 0, 0);
    step("ld6_q3", 1, 0, 0, 1, 0, 0,    3'd3, 0, 0);

    // --- 6: behaviour at the top boundary on MODULO=8 ---
    step("rst8b",  0, 1, 0, 1, 0, 0,    3'd0, 0, 0);
    step("ld8_6",  0, 0, 0, 1, 1, 3'd6, 3'd0, 0, 0);
    step("top8_6", 0, 0, 1, 1, 0, 0,    3'd6, 0, 0);
    step("top8_7", 0, 0, 1, 1, 0, 0,    3'd7, 1, 0);
`ifdef COUNTER_SAT_EN
    step("sat8_a", 0, 0, 1, 1, 0, 0, 3'd7, 1, 1);
    step("sat8_b", 0, 0, 1, 1, 0, 0, 3'd7, 1, 1);
    step("sat8_d", 0, 0, 1, 0, 0, 0, 3'd7, 0, 1);
    step("sat8_e", 0, 0, 0, 0, 0, 0, 3'd6, 0, 0);
`else
    step("wr8_a",  0, 0, 1, 1, 0, 0, 3'd0, 0, 1);
    step("wr8_b",  0, 0, 1, 1, 0, 0, 3'd1, 0, 0);
    step("wr8_d",  0, 0, 1, 0, 0, 0, 3'd2, 0, 0);
    step("wr8_e",  0, 0, 0, 0, 0, 0, 3'd1, 0, 0);
`endif

    @(negedge clk);
    #5;
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
